fpau_op_sequencer: RTL and testbench

- Single-issue controller that sits between an operation requester and the shared FPAU datapath: add, sub, mult, div and rootsquare, each with its own special-case result stage.
- Accepts one request at a time over a valid/ready handshake and screens the operands.
- NaN operands, negative-root operands and illegal opcodes are resolved locally without occupying the datapath. All other requests are dispatched with a start pulse, and the controller waits for done under a timeout watchdog.
- Returns the result over a valid/ready response handshake and keeps a completed-operation counter.

---
 rtl/fpau_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_fpau_op_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpau_op_sequencer.sv
// fpau_op_sequencer: single-issue controller that screens FPAU requests,
// resolves NaN / negative-root / illegal-opcode cases locally, dispatches the
// rest to the shared datapath under a watchdog, and returns one response each.
module fpau_op_sequencer #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             dp_start,
    output logic [2:0]       dp_op,
    output logic [31:0]      dp_a,
    output logic [31:0]      dp_b,
    input  logic             dp_done,
    input  logic [31:0]      dp_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_bypass,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    localparam int              WD_W      = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]     CANON_NAN = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic [WD_W-1:0] watchdog;
    logic            accept;
    logic            bypass_now;
    logic            illegal_now;
    logic            wd_expired;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_neg_nonzero(input logic [31:0] x);
        return x[31] && (x[30:0] != 31'd0);
    endfunction

    // Screening of the request currently offered; B is irrelevant for rootsquare.
    always_comb begin
        accept      = req_valid && (state == S_IDLE);
        illegal_now = (req_op > 3'd4);
        bypass_now  = illegal_now
                    || is_nan(req_a)
                    || ((req_op <= 3'd3) && is_nan(req_b))
                    || ((req_op == 3'd4) && is_neg_nonzero(req_a));
        wd_expired  = (watchdog == WD_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; done beats timeout in WAIT.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        dp_start   = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    state_next = bypass_now ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                dp_start   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done || wd_expired) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latch, watchdog, response word and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_op      <= 3'd0;
            dp_a       <= 32'd0;
            dp_b       <= 32'd0;
            watchdog   <= '0;
            rsp_result <= 32'd0;
            rsp_bypass <= 1'b0;
            rsp_err    <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dp_op <= req_op;
                        dp_a  <= req_a;
                        dp_b  <= req_b;
                        if (bypass_now) begin
                            rsp_result <= CANON_NAN;
                            rsp_bypass <= 1'b1;
                            rsp_err    <= illegal_now;
                        end
                    end
                end
                S_ISSUE: begin
                    watchdog <= '0;
                end
                S_WAIT: begin
                    if (dp_done) begin
                        rsp_result <= dp_result;
                        rsp_bypass <= 1'b0;
                        rsp_err    <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_result <= CANON_NAN;
                        rsp_bypass <= 1'b0;
                        rsp_err    <= 1'b1;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        ops_done <= ops_done + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpau_op_sequencer.sv
// tb_fpau_op_sequencer: directed plus randomized checks of the FPAU op
// sequencer against a behavioural reference model; the bench plays datapath.
module tb_fpau_op_sequencer;
    localparam int          T     = 64;
    localparam int          CW    = 2;
    localparam logic [31:0] CANON = 32'h7FFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic          dp_start;
    logic [2:0]    dp_op;
    logic [31:0]   dp_a;
    logic [31:0]   dp_b;
    logic          dp_done;
    logic [31:0]   dp_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_bypass;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] ops_done;

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    fpau_op_sequencer #(.TIMEOUT_CYC(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .dp_start(dp_start), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
        .dp_done(dp_done), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_bypass(rsp_bypass), .rsp_err(rsp_err),
        .busy(busy), .ops_done(ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference classification, written on magnitudes rather than bit fields.
    function automatic bit m_nan(input logic [31:0] x);
        return (x & 32'h7FFF_FFFF) > 32'h7F80_0000;
    endfunction

    function automatic bit m_negnz(input logic [31:0] x);
        return x > 32'h8000_0000;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF);
            1:       return 32'hFF80_0000;
            2:       return 32'h7F80_0000;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One full transaction: dly = cycles after dp_start that done is driven
    // (0 = never), hold = cycles of response backpressure.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int dly, input logic [31:0] dres, input int hold);
        bit          byp;
        bit          err;
        bit          done_in_time;
        logic [31:0] exp_res;
        int          e;
        int          guard;
        byp = (op > 3'd4) || m_nan(a) || ((op < 3'd4) && m_nan(b)) || ((op == 3'd4) && m_negnz(a));
        err = (op > 3'd4);
        exp_res = CANON;
        guard = 0;
        while (!req_ready && guard < 200) begin
            tick();
            guard++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        tick();
        req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
        chk("dp_op_latch", dp_op, op);
        chk("dp_a_latch", dp_a, a);
        chk("dp_b_latch", dp_b, b);
        if (byp) begin
            chk("bypass_no_start", dp_start, 0);
            chk("bypass_rsp_lat", rsp_valid, 1);
        end else begin
            chk("dispatch_start", dp_start, 1);
            chk("dispatch_no_rsp", rsp_valid, 0);
            done_in_time = (dly >= 1) && (dly <= T);
            e = done_in_time ? dly + 1 : T + 1;
            err = !done_in_time;
            exp_res = done_in_time ? dres : CANON;
            for (int k = 1; k < e; k++) begin
                tick();
                dp_done   = (k == dly);
                dp_result = (k == dly) ? dres : $urandom;
                chk("wait_quiet", {dp_start, rsp_valid}, 0);
            end
            tick();
            dp_done = 1'b0;
            chk("rsp_after_wait", rsp_valid, 1);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, exp_res);
            chk("hold_no_ready", req_ready, 0);
            chk("hold_no_accept", dp_a, a);
            tick();
        end
        req_valid = 1'b0;
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_bypass", rsp_bypass, byp);
        chk("rsp_err", rsp_err, err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        model_cnt = (model_cnt + 1) % (1 << CW);
        chk("ops_done", ops_done, model_cnt);
        chk("rsp_cleared", rsp_valid, 0);
        chk("back_idle", req_ready, 1);
        chk("no_spurious_start", dp_start, 0);
    endtask

    initial begin
        logic [CW-1:0] cnt_before;
        logic [2:0]    rop;
        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
        dp_done = 1'b0; dp_result = 32'd0; rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_dp_a", dp_a, 0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", req_ready, 1);

        // Directed cases.
        run_op(3'b000, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 0);
        chk("add_count", ops_done, 1);
        run_op(3'b010, 32'h7FC0_0000, 32'h3F80_0000, 0, 32'd0, 0);
        run_op(3'b100, 32'hBF80_0000, 32'h7FC0_0000, 0, 32'd0, 0);
        run_op(3'b110, 32'h3F80_0000, 32'h3F80_0000, 0, 32'd0, 0);
        run_op(3'b011, 32'h3F80_0000, 32'h4000_0000, 0, 32'd0, 0);

        // Late done while idle must be ignored.
        cnt_before = ops_done;
        dp_done = 1'b1; dp_result = 32'h1234_5678;
        tick();
        dp_done = 1'b0;
        chk("late_done_valid", rsp_valid, 0);
        chk("late_done_busy", busy, 0);
        chk("late_done_cnt", ops_done, cnt_before);

        run_op(3'b001, 32'h4040_0000, 32'h3F80_0000, 2, 32'h4000_0000, 5);
        run_op(3'b000, 32'h3F80_0000, 32'h3F80_0000, T, 32'h4000_0000, 0);
        run_op(3'b010, 32'h3F80_0000, 32'h3F80_0000, T + 1, 32'h4000_0000, 0);
        run_op(3'b100, 32'h8000_0000, 32'h0, 1, 32'h8000_0000, 1);
        run_op(3'b011, 32'h3F80_0000, 32'hFF80_0000, 4, 32'hBF80_0000, 0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_op(rop, pick_operand(), pick_operand(), $urandom_range(1, 10), $urandom,
                   $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of WAIT.
        req_valid = 1'b1; req_op = 3'b000; req_a = 32'h3F80_0000; req_b = 32'h3F80_0000;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dp_a", dp_a, 0);
        chk("mid_rst_cnt", ops_done, 0);
        tick();
        rst = 1'b0;
        model_cnt = 0;
        dp_done = 1'b1; dp_result = 32'h4000_0000;
        tick();
        dp_done = 1'b0;
        tick();
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_result", rsp_result, 0);
        chk("post_rst_bypass", {rsp_bypass, rsp_err}, 0);
        chk("post_rst_cnt", ops_done, 0);
        chk("post_rst_ready", req_ready, 1);

        // Counter wrap with a 2-bit counter: five completions leave 1.
        for (int i = 0; i < 5; i++) begin
            run_op(3'($urandom_range(0, 4)), $urandom & 32'h3FFF_FFFF, $urandom & 32'h3FFF_FFFF,
                   $urandom_range(1, 4), $urandom, 0);
        end
        chk("wrap_count", ops_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
